csr_file_m: RTL

- Parametrised machine-mode CSR file for the Otter core; successor to the single-interrupt mie/mtvec/mepc block.
- Supports mstatus MIE/MPIE stacking, mret, multiple prioritised external interrupt lines, vectored mtvec, mcause, mscratch, and 64-bit mcycle/minstret counters.
- Supports csrrw, csrrs and csrrc semantics.
- Sits beside the register file; the control unit drives ops, trap_take and mret at instruction boundaries.

---
 rtl/csr_file_m.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/csr_file_m.sv
// rtl/csr_file_m.sv - machine-mode CSR file with prioritised interrupts and counters
module csr_file_m #(
    parameter int          NUM_IRQ         = 4,
    parameter int          ENABLE_COUNTERS = 1,
    parameter logic [31:0] MTVEC_RESET     = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         csr_op,
    input  logic [11:0]        addr,
    input  logic [31:0]        w_data,
    output logic [31:0]        r_data,
    output logic               csr_illegal,
    input  logic [31:0]        prog_count,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               trap_take,
    input  logic               mret,
    input  logic               instr_retired,
    output logic               int_pending,
    output logic [31:0]        trap_vector,
    output logic [31:0]        csr_mepc
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MINSTRH  = 12'hB82;
    localparam bit          CNT_EN     = (ENABLE_COUNTERS != 0);

    logic               mstatus_mie_q, mstatus_mie_d;
    logic               mstatus_mpie_q, mstatus_mpie_d;
    logic [NUM_IRQ-1:0] mie_en_q, mie_en_d;
    logic [NUM_IRQ-1:0] mip_q, mip_d;
    logic [31:0]        mtvec_q, mtvec_d;
    logic [31:0]        mscratch_q, mscratch_d;
    logic [31:0]        mepc_q, mepc_d;
    logic [31:0]        mcause_q, mcause_d;
    logic [63:0]        mcycle_q, mcycle_d;
    logic [63:0]        minstret_q, minstret_d;

    logic               impl;
    logic [31:0]        mie_full, mip_full;
    logic [31:0]        wr_val;
    logic               wr_en;
    logic [NUM_IRQ-1:0] active;
    logic [4:0]         win_code;
    logic [31:0]        trap_cause;
    logic [31:0]        tvec_base;

    // Address decode and read mux; r_data always shows the pre-write value
    always_comb begin
        mie_full = '0;
        mip_full = '0;
        mie_full[16 +: NUM_IRQ] = mie_en_q;
        mip_full[16 +: NUM_IRQ] = mip_q;
        impl   = 1'b1;
        r_data = '0;
        case (addr)
            A_MSTATUS:  r_data = {24'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
            A_MIE:      r_data = mie_full;
            A_MTVEC:    r_data = mtvec_q;
            A_MSCRATCH: r_data = mscratch_q;
            A_MEPC:     r_data = mepc_q;
            A_MCAUSE:   r_data = mcause_q;
            A_MIP:      r_data = mip_full;
            A_MCYCLE:   begin impl = CNT_EN; r_data = CNT_EN ? mcycle_q[31:0]    : '0; end
            A_MCYCLEH:  begin impl = CNT_EN; r_data = CNT_EN ? mcycle_q[63:32]   : '0; end
            A_MINSTRET: begin impl = CNT_EN; r_data = CNT_EN ? minstret_q[31:0]  : '0; end
            A_MINSTRH:  begin impl = CNT_EN; r_data = CNT_EN ? minstret_q[63:32] : '0; end
            default:    impl = 1'b0;
        endcase
        csr_illegal = (csr_op != 2'b00) && !impl;
    end

    // Read-modify-write operand; trap entry and mret both pre-empt the CSR write
    always_comb begin
        case (csr_op)
            2'b01:   wr_val = w_data;
            2'b10:   wr_val = r_data | w_data;
            2'b11:   wr_val = r_data & ~w_data;
            default: wr_val = r_data;
        endcase
        wr_en = (csr_op != 2'b00) && impl && !trap_take && !mret;
    end

    // Lowest-numbered enabled pending line wins; with none the code defaults to 16
    always_comb begin
        active   = mip_q & mie_en_q;
        win_code = 5'd16;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) win_code = 5'(16 + i);
        end
        int_pending = mstatus_mie_q && (|active);
        trap_cause  = {27'h400_0000, int_pending ? win_code : 5'd16};
        tvec_base   = {mtvec_q[31:2], 2'b00};
        trap_vector = mtvec_q[0] ? tvec_base + {25'b0, win_code, 2'b00} : tvec_base;
        csr_mepc    = mepc_q;
    end

    // Next-state: trap entry beats mret beats CSR write; counters tick regardless
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_en_d       = mie_en_q;
        mip_d          = irq;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mcycle_d       = mcycle_q + 64'd1;
        minstret_d     = minstret_q + {63'b0, instr_retired};

        if (trap_take) begin
            mepc_d         = prog_count & 32'hFFFF_FFFC;
            mcause_d       = trap_cause;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (wr_en) begin
            case (addr)
                A_MSTATUS: begin
                    mstatus_mie_d  = wr_val[3];
                    mstatus_mpie_d = wr_val[7];
                end
                A_MIE:      mie_en_d   = wr_val[16 +: NUM_IRQ];
                A_MTVEC:    mtvec_d    = {wr_val[31:2], 1'b0, wr_val[0]};
                A_MSCRATCH: mscratch_d = wr_val;
                A_MEPC:     mepc_d     = {wr_val[31:2], 2'b00};
                A_MCAUSE:   mcause_d   = wr_val;
                A_MCYCLE:   mcycle_d   = {mcycle_q[63:32], wr_val};
                A_MCYCLEH:  mcycle_d   = {wr_val, mcycle_q[31:0]};
                A_MINSTRET: minstret_d = {minstret_q[63:32], wr_val};
                A_MINSTRH:  minstret_d = {wr_val, minstret_q[31:0]};
                default:    ;
            endcase
        end

        if (!CNT_EN) begin
            mcycle_d   = '0;
            minstret_d = '0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_en_q       <= '0;
            mip_q          <= '0;
            mtvec_q        <= MTVEC_RESET;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_en_q       <= mie_en_d;
            mip_q          <= mip_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

endmodule
